// File: rtl/sprite_regs.sv
// Sprite attribute register block for the console bus.
// The bus initiator writes shadow copies of per-sprite X/Y/ATTR bytes.
// Each vertical-sync rise commits the shadows to the active registers
// that feed the renderers, so a frame never shows a half-updated sprite.
// The block also keeps a read-to-clear frame flag and a free-running
// frame counter for software pacing.
module sprite_regs #(
   parameter int NSPR = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [11:0]           addr,
   input  logic                  we,
   input  logic                  oe,
   input  logic [7:0]            di,
   output logic [7:0]            dout,
   input  logic                  vsync,
   output logic [8*NSPR-1:0]     spr_x,
   output logic [7*NSPR-1:0]     spr_y,
   output logic [4*NSPR-1:0]     spr_color,
   output logic [NSPR-1:0]       spr_en,
   output logic                  frame_irq
);

   localparam logic [4:0] OFF_STATUS   = 5'h10;
   localparam logic [4:0] OFF_FRAMECNT = 5'h11;
   localparam logic [4:0] OFF_CTRL     = 5'h12;

   // Shadow registers (bus side)
   logic [7:0] x_sh_q     [NSPR];
   logic [7:0] x_sh_d     [NSPR];
   logic [6:0] y_sh_q     [NSPR];
   logic [6:0] y_sh_d     [NSPR];
   logic [3:0] color_sh_q [NSPR];
   logic [3:0] color_sh_d [NSPR];
   logic       en_sh_q    [NSPR];
   logic       en_sh_d    [NSPR];

   // Active registers (renderer side)
   logic [7:0] x_act_q     [NSPR];
   logic [7:0] x_act_d     [NSPR];
   logic [6:0] y_act_q     [NSPR];
   logic [6:0] y_act_d     [NSPR];
   logic [3:0] color_act_q [NSPR];
   logic [3:0] color_act_d [NSPR];
   logic       en_act_q    [NSPR];
   logic       en_act_d    [NSPR];

   // Control, status and read path
   logic       ctrl_q, ctrl_d;
   logic       flag_q, flag_d;
   logic [7:0] framecnt_q, framecnt_d;
   logic [7:0] dout_q, dout_d;
   logic [7:0] rd_data;

   // vsync synchronizer, edge detector and post-reset arming
   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       dly_q, dly_d;
   logic [1:0] settle_q, settle_d;
   logic       armed_q, armed_d;
   logic       rise;

   logic [4:0] off;
   logic [1:0] spr_idx;
   logic       rd_en;
   logic       unused_addr;

   assign off         = addr[4:0];
   assign spr_idx     = addr[3:2];
   assign rd_en       = oe & ~we;
   assign unused_addr = ^addr[11:5];

   // Read multiplexer: sprite offsets return shadow values, unused bits read 0
   always_comb begin
      rd_data = 8'h00;
      if (!off[4]) begin
         case (off[1:0])
            2'd0:    rd_data = x_sh_q[spr_idx];
            2'd1:    rd_data = {1'b0, y_sh_q[spr_idx]};
            2'd2:    rd_data = {en_sh_q[spr_idx], 3'b000, color_sh_q[spr_idx]};
            default: rd_data = 8'h00;
         endcase
      end else begin
         case (off)
            OFF_STATUS:   rd_data = {7'h00, flag_q};
            OFF_FRAMECNT: rd_data = framecnt_q;
            OFF_CTRL:     rd_data = {7'h00, ctrl_q};
            default:      rd_data = 8'h00;
         endcase
      end
   end

   // Next-state logic: bus writes, read-clear of the flag, and the vsync commit.
   // A vsync that is already high when reset releases must not count as a rise,
   // so detection is armed only once the settled synchronizer has been seen low.
   always_comb begin
      x_sh_d      = x_sh_q;
      y_sh_d      = y_sh_q;
      color_sh_d  = color_sh_q;
      en_sh_d     = en_sh_q;
      x_act_d     = x_act_q;
      y_act_d     = y_act_q;
      color_act_d = color_act_q;
      en_act_d    = en_act_q;
      ctrl_d      = ctrl_q;
      flag_d      = flag_q;
      framecnt_d  = framecnt_q;

      sync1_d  = vsync;
      sync2_d  = sync1_q;
      dly_d    = sync2_q;
      settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
      armed_d  = armed_q | ((settle_q == 2'd2) & ~sync2_q);
      rise     = sync2_q & ~dly_q & armed_q;

      if (we) begin
         if (!off[4]) begin
            case (off[1:0])
               2'd0: x_sh_d[spr_idx] = di;
               2'd1: y_sh_d[spr_idx] = di[6:0];
               2'd2: begin
                  en_sh_d[spr_idx]    = di[7];
                  color_sh_d[spr_idx] = di[3:0];
               end
               default: ;
            endcase
         end else if (off == OFF_CTRL) begin
            ctrl_d = di[0];
         end
      end

      if (rd_en && off == OFF_STATUS) begin
         flag_d = 1'b0;
      end

      dout_d = rd_en ? rd_data : 8'h00;

      if (rise) begin
         flag_d     = 1'b1;
         framecnt_d = framecnt_q + 8'd1;
         if (ctrl_q) begin
            x_act_d     = x_sh_q;
            y_act_d     = y_sh_q;
            color_act_d = color_sh_q;
            en_act_d    = en_sh_q;
         end
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NSPR; i++) begin
            x_sh_q[i]      <= 8'h00;
            y_sh_q[i]      <= 7'h00;
            color_sh_q[i]  <= 4'h0;
            en_sh_q[i]     <= 1'b0;
            x_act_q[i]     <= 8'h00;
            y_act_q[i]     <= 7'h00;
            color_act_q[i] <= 4'h0;
            en_act_q[i]    <= 1'b0;
         end
         ctrl_q     <= 1'b1;
         flag_q     <= 1'b0;
         framecnt_q <= 8'h00;
         dout_q     <= 8'h00;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         dly_q      <= 1'b0;
         settle_q   <= 2'd0;
         armed_q    <= 1'b0;
      end else begin
         x_sh_q      <= x_sh_d;
         y_sh_q      <= y_sh_d;
         color_sh_q  <= color_sh_d;
         en_sh_q     <= en_sh_d;
         x_act_q     <= x_act_d;
         y_act_q     <= y_act_d;
         color_act_q <= color_act_d;
         en_act_q    <= en_act_d;
         ctrl_q      <= ctrl_d;
         flag_q      <= flag_d;
         framecnt_q  <= framecnt_d;
         dout_q      <= dout_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         dly_q       <= dly_d;
         settle_q    <= settle_d;
         armed_q     <= armed_d;
      end
   end

   // Pack the active registers onto the flat renderer buses
   always_comb begin
      spr_x     = '0;
      spr_y     = '0;
      spr_color = '0;
      spr_en    = '0;
      for (int i = 0; i < NSPR; i++) begin
         spr_x[8*i +: 8]     = x_act_q[i];
         spr_y[7*i +: 7]     = y_act_q[i];
         spr_color[4*i +: 4] = color_act_q[i];
         spr_en[i]           = en_act_q[i];
      end
   end

   assign dout      = dout_q;
   assign frame_irq = flag_q;

endmodule

// File: tb/tb_sprite_regs.sv
// Directed self-checking bench for sprite_regs: reset state, shadow/commit,
// frame flag and counter, commit hold, same-cycle collisions, reserved
// offsets and mid-frame reset.
module tb_sprite_regs;

   logic        clk;
   logic        reset;
   logic [11:0] addr;
   logic        we;
   logic        oe;
   logic [7:0]  di;
   logic [7:0]  dout;
   logic        vsync;
   logic [31:0] spr_x;
   logic [27:0] spr_y;
   logic [15:0] spr_color;
   logic [3:0]  spr_en;
   logic        frame_irq;

   int assertCount = 0;
   int failCount   = 0;

   sprite_regs #(.NSPR(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .we        (we),
      .oe        (oe),
      .di        (di),
      .dout      (dout),
      .vsync     (vsync),
      .spr_x     (spr_x),
      .spr_y     (spr_y),
      .spr_color (spr_color),
      .spr_en    (spr_en),
      .frame_irq (frame_irq)
   );

   // 100 MHz-ish free running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and log mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance n clock edges, leaving time 1 unit past the last edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one bus cycle with the given strobes
   task automatic applyStimulus(input logic w, input logic r, input logic [4:0] off, input logic [7:0] data);
      addr = {4'h5, 3'b000, off};
      di   = data;
      we   = w;
      oe   = r;
      tick(1);
      we   = 1'b0;
      oe   = 1'b0;
   endtask

   task automatic writeReg(input logic [4:0] off, input logic [7:0] data);
      applyStimulus(1'b1, 1'b0, off, data);
   endtask

   task automatic readCheck(input string tag, input logic [4:0] off, input logic [7:0] expected);
      applyStimulus(1'b0, 1'b1, off, 8'h00);
      checkOutput(tag, {24'h0, dout}, {24'h0, expected});
   endtask

   // Full vsync pulse long enough for the synchronizer, followed by a low gap
   task automatic pulseVsync();
      vsync = 1'b1;
      tick(3);
      vsync = 1'b0;
      tick(3);
   endtask

   // Raise vsync and stop inside the cycle where the rise is seen internally
   task automatic startRise();
      vsync = 1'b1;
      tick(2);
   endtask

   initial begin
      reset = 1'b0;
      vsync = 1'b0;
      we    = 1'b0;
      oe    = 1'b0;
      addr  = 12'h500;
      di    = 8'h00;
      tick(3);
      reset = 1'b1;
      tick(5);

      // Reset state
      checkOutput("rst_dout", {24'h0, dout}, 32'h0);
      checkOutput("rst_spr_en", {28'h0, spr_en}, 32'h0);
      checkOutput("rst_spr_x", spr_x, 32'h0);
      checkOutput("rst_irq", {31'h0, frame_irq}, 32'h0);
      readCheck("rst_ctrl", 5'h12, 8'h01);
      readCheck("rst_framecnt", 5'h11, 8'h00);

      // Shadow writes and exact commit latency
      writeReg(5'h00, 8'h50);
      writeReg(5'h01, 8'hBA);
      writeReg(5'h02, 8'h89);
      readCheck("rd_y0_masked", 5'h01, 8'h3A);
      readCheck("rd_attr0", 5'h02, 8'h89);
      readCheck("rd_x0", 5'h00, 8'h50);
      checkOutput("x0_before_vsync", {24'h0, spr_x[7:0]}, 32'h0);
      vsync = 1'b1;
      tick(1);
      checkOutput("x0_edge_k", {24'h0, spr_x[7:0]}, 32'h0);
      tick(1);
      checkOutput("x0_edge_k1", {24'h0, spr_x[7:0]}, 32'h0);
      tick(1);
      checkOutput("x0_edge_k2", {24'h0, spr_x[7:0]}, 32'h50);
      checkOutput("y0_commit", {25'h0, spr_y[6:0]}, 32'h3A);
      checkOutput("color0_commit", {28'h0, spr_color[3:0]}, 32'h9);
      checkOutput("en_commit", {28'h0, spr_en}, 32'h1);
      checkOutput("irq_after_rise", {31'h0, frame_irq}, 32'h1);
      vsync = 1'b0;
      tick(3);

      // Frame flag read-clear and counter wrap
      readCheck("status_first", 5'h10, 8'h01);
      readCheck("status_second", 5'h10, 8'h00);
      checkOutput("irq_cleared", {31'h0, frame_irq}, 32'h0);
      readCheck("framecnt_1", 5'h11, 8'h01);
      pulseVsync();
      checkOutput("irq_pulse", {31'h0, frame_irq}, 32'h1);
      readCheck("framecnt_2", 5'h11, 8'h02);
      for (int i = 0; i < 256; i++) begin
         pulseVsync();
      end
      readCheck("framecnt_wrap", 5'h11, 8'h02);
      readCheck("status_after_wrap", 5'h10, 8'h01);

      // Commit hold with CTRL cleared
      writeReg(5'h12, 8'h00);
      readCheck("ctrl_zero", 5'h12, 8'h00);
      writeReg(5'h04, 8'h20);
      pulseVsync();
      checkOutput("x1_held", {24'h0, spr_x[15:8]}, 32'h0);
      readCheck("framecnt_hold", 5'h11, 8'h03);
      writeReg(5'h12, 8'h01);
      pulseVsync();
      checkOutput("x1_commit", {24'h0, spr_x[15:8]}, 32'h20);
      readCheck("framecnt_4", 5'h11, 8'h04);

      // Write in the rise cycle: active takes the old shadow value
      writeReg(5'h08, 8'h11);
      pulseVsync();
      checkOutput("x2_first", {24'h0, spr_x[23:16]}, 32'h11);
      startRise();
      applyStimulus(1'b1, 1'b0, 5'h08, 8'h77);
      checkOutput("x2_collide", {24'h0, spr_x[23:16]}, 32'h11);
      vsync = 1'b0;
      tick(3);
      readCheck("x2_shadow", 5'h08, 8'h77);
      pulseVsync();
      checkOutput("x2_next_frame", {24'h0, spr_x[23:16]}, 32'h77);

      // STATUS read in the rise cycle: old value returned, set wins
      readCheck("status_pre_clear", 5'h10, 8'h01);
      startRise();
      applyStimulus(1'b0, 1'b1, 5'h10, 8'h00);
      checkOutput("status_collide_dout", {24'h0, dout}, 32'h0);
      checkOutput("status_collide_irq", {31'h0, frame_irq}, 32'h1);
      vsync = 1'b0;
      tick(3);

      // CTRL write in the rise cycle: commit uses the old CTRL
      writeReg(5'h00, 8'h99);
      startRise();
      applyStimulus(1'b1, 1'b0, 5'h12, 8'h00);
      checkOutput("ctrl_collide_commit", {24'h0, spr_x[7:0]}, 32'h99);
      vsync = 1'b0;
      tick(3);
      readCheck("ctrl_collide_new", 5'h12, 8'h00);
      writeReg(5'h12, 8'h01);
      readCheck("framecnt_9", 5'h11, 8'h09);

      // Reserved and unmapped offsets, and simultaneous we/oe
      writeReg(5'h03, 8'hFF);
      writeReg(5'h1F, 8'hFF);
      readCheck("rd_reserved_03", 5'h03, 8'h00);
      readCheck("rd_unmapped_1f", 5'h1F, 8'h00);
      applyStimulus(1'b1, 1'b1, 5'h0C, 8'h5A);
      checkOutput("we_oe_dout", {24'h0, dout}, 32'h0);
      readCheck("we_oe_wrote", 5'h0C, 8'h5A);
      checkOutput("irq_before_reset", {31'h0, frame_irq}, 32'h1);

      // Mid-frame reset with vsync held high across release
      vsync = 1'b1;
      tick(1);
      reset = 1'b0;
      #2;
      checkOutput("midrst_spr_x", spr_x, 32'h0);
      checkOutput("midrst_spr_en", {28'h0, spr_en}, 32'h0);
      checkOutput("midrst_irq", {31'h0, frame_irq}, 32'h0);
      tick(2);
      reset = 1'b1;
      tick(6);
      checkOutput("release_high_irq", {31'h0, frame_irq}, 32'h0);
      readCheck("release_high_cnt", 5'h11, 8'h00);
      readCheck("release_x0", 5'h00, 8'h00);
      readCheck("release_ctrl", 5'h12, 8'h01);
      vsync = 1'b0;
      tick(4);
      vsync = 1'b1;
      tick(4);
      checkOutput("rearm_irq", {31'h0, frame_irq}, 32'h1);
      readCheck("rearm_cnt", 5'h11, 8'h01);
      vsync = 1'b0;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
